// File: rtl/lcm_report_arbiter_if.sv
// lcm_report_arbiter_if: bundles the report-path signals between packet sources and the arbiter
//   iv_req/ov_ack            per-source request level and one-cycle grant pulse
//   iv_data/iv_data_wr       concatenated source words (source i at [i*DW +: DW]) and word-valids
//   i_out_almost_full        downstream backpressure, gates new grants only
//   ov_data/o_data_wr        forwarded word and its valid
//   ov_timeout_cnt/o_busy    saturating watchdog-abort count and packet-in-flight flag
interface lcm_report_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 134
);
  logic [NUM_REQ-1:0]    iv_req;
  logic [NUM_REQ-1:0]    ov_ack;
  logic [NUM_REQ*DW-1:0] iv_data;
  logic [NUM_REQ-1:0]    iv_data_wr;
  logic                  i_out_almost_full;
  logic [DW-1:0]         ov_data;
  logic                  o_data_wr;
  logic [15:0]           ov_timeout_cnt;
  logic                  o_busy;
  modport slave (
    input  iv_req, iv_data, iv_data_wr, i_out_almost_full,
    output ov_ack, ov_data, o_data_wr, ov_timeout_cnt, o_busy
  );
  modport master (
    output iv_req, iv_data, iv_data_wr, i_out_almost_full,
    input  ov_ack, ov_data, o_data_wr, ov_timeout_cnt, o_busy
  );
endinterface

// File: rtl/lcm_report_arbiter.sv
// lcm_report_arbiter: round-robin, packet-granular arbiter sharing one report path among NUM_REQ sources
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   io_bus  slave side of lcm_report_arbiter_if (requests/data in, grant and forwarded word out)
module lcm_report_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DW          = 134,
  parameter int MAX_PKT_CYC = 256
) (
  input logic clk,
  input logic rst_n,
  lcm_report_arbiter_if.slave io_bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(MAX_PKT_CYC);
  typedef enum logic [1:0] {IDLE, GRANT, XFER, ABORT} state_t;
  state_t          r_state, w_next;
  logic [PW-1:0]   r_ptr, r_win, w_pick, w_idx, w_win_inc;
  logic [WW-1:0]   r_wd;
  logic [DW-1:0]   r_data, w_word;
  logic            r_wr, r_tail_out, w_wr, w_tail, w_wd_exp;
  logic [15:0]     r_to_cnt;
  assign w_word    = DW'(io_bus.iv_data >> (int'(r_win) * DW));
  assign w_wr      = io_bus.iv_data_wr[r_win];
  assign w_tail    = w_wr && (w_word[DW-1 -: 2] == 2'b10);
  // Watchdog reads MAX_PKT_CYC-2 in the cycle whose increment reaches MAX_PKT_CYC-1
  assign w_wd_exp  = r_wd == WW'(MAX_PKT_CYC - 2);
  assign w_win_inc = (r_win == PW'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
  // Lowest offset from the pointer wins, so the loop runs from the far end down
  always_comb begin
    w_pick = r_ptr;
    w_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = PW'((int'(r_ptr) + k) % NUM_REQ);
      if (io_bus.iv_req[w_idx]) w_pick = w_idx;
    end
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = (|io_bus.iv_req && !io_bus.i_out_almost_full) ? GRANT : IDLE;
      GRANT:   w_next = XFER;
      XFER:    w_next = w_tail ? IDLE : w_wd_exp ? ABORT : XFER;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_win      <= '0;
      r_wd       <= '0;
      r_data     <= '0;
      r_wr       <= 1'b0;
      r_tail_out <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_state    <= w_next;
      r_wr       <= 1'b0;
      r_tail_out <= 1'b0;
      if (r_state == IDLE && w_next == GRANT) r_win <= w_pick;
      if (r_state == GRANT) r_wd <= '0;
      if (r_state == XFER) begin
        r_wd <= r_wd + 1'b1;
        if (w_wr) begin
          r_data <= w_word;
          r_wr   <= 1'b1;
        end
        if (w_tail) begin
          r_ptr      <= w_win_inc;
          r_tail_out <= 1'b1;
        end
      end
      if (r_state == ABORT) begin
        r_data     <= {2'b10, {(DW-2){1'b0}}};
        r_wr       <= 1'b1;
        r_tail_out <= 1'b1;
        r_ptr      <= w_win_inc;
        r_to_cnt   <= r_to_cnt + {15'b0, ~&r_to_cnt};
      end
    end
  end
  assign io_bus.ov_ack         = (r_state == GRANT) ? NUM_REQ'(1) << r_win : '0;
  assign io_bus.ov_data        = r_data;
  assign io_bus.o_data_wr      = r_wr;
  assign io_bus.ov_timeout_cnt = r_to_cnt;
  // Busy stays up through the cycle the tail sits on ov_data
  assign io_bus.o_busy         = (r_state != IDLE) || r_tail_out;
endmodule

// File: tb/tb_lcm_report_arbiter.sv
// tb_lcm_report_arbiter: random packet sources checked against a packet-level reference model
module tb_lcm_report_arbiter;
  localparam int N    = 4;
  localparam int DW   = 134;
  localparam int MAXC = 16;
  typedef struct {int cyc; logic [DW-1:0] d;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  lcm_report_arbiter_if #(.NUM_REQ(N), .DW(DW)) bus ();
  lcm_report_arbiter #(.NUM_REQ(N), .DW(DW), .MAX_PKT_CYC(MAXC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io_bus(bus)
  );
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  int n, ptr, act, g, idle_from, busy_until, to_exp, to_pend;
  logic [N-1:0] exp_ack;
  logic [DW-1:0] last_d;
  logic [DW-1:0] synth;
  bit src_req[N], src_wr[N], sending[N], stall[N], first[N];
  int left[N];
  logic [DW-1:0] dat[N];
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] rnd_word(input logic [1:0] fr);
    return {fr, 4'($urandom), $urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic int choose(input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (((r >> ((ptr + k) % N)) & N'(1)) != 0) return (ptr + k) % N;
    return -1;
  endfunction
  task automatic model_reset();
    q.delete();
    n = 0; ptr = 0; act = -1; g = 0; idle_from = 0; busy_until = -1;
    to_exp = 0; to_pend = -1; exp_ack = '0; last_d = '0;
    for (int s = 0; s < N; s++) begin
      src_req[s] = 0; src_wr[s] = 0; sending[s] = 0; stall[s] = 0; first[s] = 0; left[s] = 0; dat[s] = '0;
    end
    bus.iv_req = '0;
    bus.iv_data_wr = '0;
    bus.iv_data = '0;
    bus.i_out_almost_full = 1'b0;
  endtask
  task automatic step();
    logic [N-1:0] req, wr;
    logic [N*DW-1:0] data;
    logic af, exp_wr, wr_a;
    logic [DW-1:0] d_a;
    logic [1:0] fr;
    int w;
    @(negedge clk);
    n++;
    if (to_pend == n) to_exp++;
    check("ack", DW'(bus.ov_ack), DW'(exp_ack));
    check("busy", DW'(bus.o_busy), DW'((act >= 0 && n >= g) || n <= busy_until));
    exp_wr = q.size() > 0 && q[0].cyc == n;
    check("data_wr", DW'(bus.o_data_wr), DW'(exp_wr));
    if (exp_wr) begin
      check("data", bus.ov_data, q[0].d);
      last_d = q[0].d;
      void'(q.pop_front());
    end else check("data_hold", bus.ov_data, last_d);
    check("timeout_cnt", DW'(bus.ov_timeout_cnt), DW'(to_exp));
    for (int s = 0; s < N; s++) begin
      src_wr[s] = 0;
      fr = 2'($urandom);
      if (((bus.ov_ack >> s) & N'(1)) != 0) begin
        src_req[s] = 0; sending[s] = 1; first[s] = 1;
        left[s] = $urandom_range(1, 4); stall[s] = ($urandom % 8) == 0;
      end else if (sending[s]) begin
        if ($urandom % 3 != 0) begin
          src_wr[s] = 1;
          fr = stall[s] ? 2'b01 : left[s] == 1 ? 2'b10 : first[s] ? (($urandom % 6 == 0) ? 2'b11 : 2'b01) : 2'b11;
          first[s] = 0;
          left[s]--;
          if (stall[s] || left[s] == 0) sending[s] = 0;
        end
      end else begin
        src_wr[s] = ($urandom % 8) == 0;
        if (!src_req[s] && $urandom % 4 == 0) src_req[s] = 1;
      end
      dat[s] = rnd_word(fr);
    end
    req = '0; wr = '0; data = '0;
    for (int s = 0; s < N; s++) begin
      req  |= N'(src_req[s]) << s;
      wr   |= N'(src_wr[s]) << s;
      data |= (N*DW)'(dat[s]) << (s * DW);
    end
    af = ($urandom % 5) == 0;
    bus.iv_req = req;
    bus.iv_data_wr = wr;
    bus.iv_data = data;
    bus.i_out_almost_full = af;
    exp_ack = '0;
    if (act < 0) begin
      if (n >= idle_from && |req && !af) begin
        w = choose(req);
        exp_ack = N'(1) << w;
        act = w;
        g = n + 1;
      end
    end else if (n >= g + 1) begin
      wr_a = ((wr >> act) & N'(1)) != 0;
      d_a = DW'(data >> (act * DW));
      if (wr_a) q.push_back('{cyc: n + 1, d: d_a});
      if (wr_a && d_a[DW-1 -: 2] == 2'b10) begin
        ptr = (act + 1) % N; idle_from = n + 1; busy_until = n + 1; act = -1;
      end else if (n - g == MAXC - 1) begin
        q.push_back('{cyc: n + 2, d: synth});
        to_pend = n + 2;
        ptr = (act + 1) % N; idle_from = n + 2; busy_until = n + 2; act = -1;
      end
    end
  endtask
  initial begin
    bit found;
    synth = '0;
    synth[DW-1 -: 2] = 2'b10;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ack", DW'(bus.ov_ack), '0);
    check("rst_data", bus.ov_data, '0);
    check("rst_wr", DW'(bus.o_data_wr), '0);
    check("rst_cnt", DW'(bus.ov_timeout_cnt), '0);
    check("rst_busy", DW'(bus.o_busy), '0);
    rst_n = 1'b1;
    repeat (3000) step();
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      found = act >= 0 && n >= g + 2;
    end
    check("find_xfer", DW'(found), DW'(1));
    #1 rst_n = 1'b0;
    #1;
    check("arst_ack", DW'(bus.ov_ack), '0);
    check("arst_data", bus.ov_data, '0);
    check("arst_wr", DW'(bus.o_data_wr), '0);
    check("arst_cnt", DW'(bus.ov_timeout_cnt), '0);
    check("arst_busy", DW'(bus.o_busy), '0);
    @(negedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2000) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
